spi_slave_interface_2: RTL and testbench

//  SPI slave (mode 0, MSB first, single clk domain) wrapped around a 256x8 single-port RAM.

---
 rtl/spi_slave_interface_2.sv | 159 +++++++++++++++
 tb/tb_spi_slave_interface_2.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_interface_2.sv
// SPI mode-0 slave (MSB first, sampled on clk) in front of a 256x8 single-port RAM.
// Frames are {cmd[1:0], payload[7:0]}; cmd 11 returns the byte at rd_addr on MISO.
module spi_slave_interface_2 #(
    parameter int MEM_DEPTH      = 256,
    parameter int MEM_ADDR_SIZE  = 8,
    parameter int MEM_INPUT_SIZE = 10,
    parameter int MEM_WORD_SIZE  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO
);

    localparam int RX_CNT_W = $clog2(MEM_INPUT_SIZE + 1);
    localparam int TX_CNT_W = $clog2(MEM_WORD_SIZE + 1);
    localparam logic [RX_CNT_W-1:0] RX_LAST = RX_CNT_W'(MEM_INPUT_SIZE - 1);
    localparam logic [RX_CNT_W-1:0] RX_DONE = RX_CNT_W'(MEM_INPUT_SIZE);
    localparam logic [TX_CNT_W-1:0] TX_LEN  = TX_CNT_W'(MEM_WORD_SIZE);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    logic [2:0]                state;
    logic [RX_CNT_W-1:0]       rx_cnt;
    logic [MEM_INPUT_SIZE-1:0] rx_data;
    logic                      rx_valid;
    logic [1:0]                rx_cmd;
    logic [MEM_WORD_SIZE-1:0]  rx_payload;
    logic                      shifting;
    logic                      rx_last_bit;

    logic [MEM_ADDR_SIZE-1:0]  wr_addr;
    logic [MEM_ADDR_SIZE-1:0]  rd_addr;
    logic                      rd_flag;
    logic [MEM_WORD_SIZE-1:0]  mem [MEM_DEPTH];
    logic [MEM_WORD_SIZE-1:0]  dout;

    logic                      tx_valid;
    logic                      tx_busy;
    logic [TX_CNT_W-1:0]       tx_cnt;
    logic [MEM_WORD_SIZE-1:0]  tx_shift;

    assign rx_cmd      = rx_data[MEM_INPUT_SIZE-1 -: 2];
    assign rx_payload  = rx_data[MEM_WORD_SIZE-1:0];
    assign shifting    = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    assign rx_last_bit = shifting && (rx_cnt == RX_LAST);

    // CHK_CMD only peeks at the command MSB; the full word is shifted afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (SS_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:      state <= CHK_CMD;
                CHK_CMD:   state <= MOSI ? (rd_flag ? READ_DATA : READ_ADD) : WRITE;
                WRITE:     state <= WRITE;
                READ_ADD:  state <= READ_ADD;
                READ_DATA: state <= READ_DATA;
                default:   state <= IDLE;
            endcase
        end
    end

    // Receive shifter: exactly MEM_INPUT_SIZE bits per frame, extras ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rd_flag  <= 1'b0;
        end else if (SS_n) begin
            rx_cnt   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (shifting && (rx_cnt != RX_DONE)) begin
                rx_data <= {rx_data[MEM_INPUT_SIZE-2:0], MOSI};
                rx_cnt  <= rx_cnt + 1'b1;
            end
            if (rx_last_bit) begin
                rx_valid <= 1'b1;
                if (state == READ_ADD) begin
                    rd_flag <= 1'b1;
                end else if (state == READ_DATA) begin
                    rd_flag <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else if (rx_valid) begin
            if (rx_cmd == CMD_WR_ADDR) begin
                wr_addr <= rx_payload[MEM_ADDR_SIZE-1:0];
            end else if (rx_cmd == CMD_RD_ADDR) begin
                rd_addr <= rx_payload[MEM_ADDR_SIZE-1:0];
            end
        end
    end

    // RAM array and read port carry no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rx_valid && (rx_cmd == CMD_WR_DATA)) begin
            mem[wr_addr] <= rx_payload;
        end
        if (rx_valid && (rx_cmd == CMD_RD_DATA)) begin
            dout <= mem[rd_addr];
        end
    end

    // tx_valid at E1, load at E2, bits on E3..E10, MISO back to 0 at E11.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_shift <= '0;
            MISO     <= 1'b0;
        end else if (SS_n) begin
            tx_valid <= 1'b0;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            MISO     <= 1'b0;
        end else if (rx_valid && (rx_cmd == CMD_RD_DATA)) begin
            tx_valid <= 1'b1;
        end else if (tx_valid && !tx_busy) begin
            tx_shift <= dout;
            tx_cnt   <= '0;
            tx_busy  <= 1'b1;
        end else if (tx_busy) begin
            if (tx_cnt != TX_LEN) begin
                MISO     <= tx_shift[MEM_WORD_SIZE-1];
                tx_shift <= {tx_shift[MEM_WORD_SIZE-2:0], 1'b0};
                tx_cnt   <= tx_cnt + 1'b1;
            end else begin
                MISO     <= 1'b0;
                tx_busy  <= 1'b0;
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_interface_2.sv
// Directed bench for spi_slave_interface_2: frame-level reference model checked every
// cycle on MISO and rd_flag, plus literal checks on the bytes read back.
module tb_spi_slave_interface_2;

    logic clk;
    logic rst_n;
    logic SS_n;
    logic MOSI;
    logic MISO;

    int checks_total;
    int checks_passed;

    spi_slave_interface_2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .SS_n  (SS_n),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Counts edges since SS_n fell: edge 1 leaves IDLE, edge 2 carries the command
    // MSB, edges 3..12 carry the 10-bit word (edge 12 is E0).
    int         m_edge;
    logic       m_cmd_msb;
    logic [9:0] m_word;
    logic [7:0] m_mem [256];
    logic [7:0] m_wa;
    logic [7:0] m_ra;
    logic       m_rd_flag;
    logic       m_tx_on;
    logic [7:0] m_tx_byte;
    logic       exp_miso;

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    end

    always @(posedge clk or negedge rst_n) begin
        int k;
        if (!rst_n) begin
            m_edge = 0; m_word = '0; m_cmd_msb = 1'b0;
            m_wa = '0; m_ra = '0; m_rd_flag = 1'b0;
            m_tx_on = 1'b0; exp_miso = 1'b0;
        end else if (SS_n) begin
            m_edge = 0; m_word = '0; m_tx_on = 1'b0; exp_miso = 1'b0;
        end else begin
            m_edge++;
            if (m_edge == 2) m_cmd_msb = MOSI;
            if (m_edge >= 3 && m_edge <= 12) m_word = {m_word[8:0], MOSI};
            if (m_edge == 12) begin
                case (m_word[9:8])
                    2'b00: m_wa = m_word[7:0];
                    2'b01: m_mem[m_wa] = m_word[7:0];
                    2'b10: m_ra = m_word[7:0];
                    default: begin
                        m_tx_byte = m_mem[m_ra];
                        m_tx_on = 1'b1;
                    end
                endcase
                // read-class frames alternate address/data phases
                if (m_cmd_msb) m_rd_flag = !m_rd_flag;
            end
            exp_miso = 1'b0;
            k = m_edge - 12;
            if (m_tx_on && k >= 3 && k <= 10) exp_miso = m_tx_byte[10-k];
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("miso_cycle", {7'd0, MISO}, {7'd0, exp_miso});
            check("rd_flag_cycle", {7'd0, dut.rd_flag}, {7'd0, m_rd_flag});
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input logic ss, input logic mosi);
        @(negedge clk);
        SS_n = ss;
        MOSI = mosi;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_bits(input logic [9:0] w);
        tick(1'b0, 1'b0);
        tick(1'b0, w[9]);
        for (int i = 9; i >= 0; i--) tick(1'b0, w[i]);
    endtask

    task automatic send_frame(input logic [9:0] w);
        frame_bits(w);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    task automatic read_frame(output logic [7:0] b);
        b = '0;
        frame_bits(10'b11_0000_0000);
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0, 1'b0);
            if (k >= 3 && k <= 10) b[10-k] = MISO;
        end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rb;
        checks_total = 0;
        checks_passed = 0;
        rst_n = 1'b0;
        SS_n = 1'b1;
        MOSI = 1'b0;

        // 1. reset with clock running
        repeat (3) @(posedge clk);
        #1;
        check("reset_miso", {7'd0, MISO}, 8'h00);
        check("reset_rd_flag", {7'd0, dut.rd_flag}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick(1'b1, 1'b0);
        check("idle_miso", {7'd0, MISO}, 8'h00);

        // 2. write 0x8A to address 0x01
        send_frame(10'b00_00000001);
        send_frame(10'b01_10001010);
        check("model_mem1", m_mem[1], 8'h8A);

        // 3. read it back
        send_frame(10'b10_00000001);
        check("rd_flag_after_rd_addr", {7'd0, dut.rd_flag}, 8'h01);
        read_frame(rb);
        check("read_addr01", rb, 8'h8A);
        check("rd_flag_after_rd_data", {7'd0, dut.rd_flag}, 8'h00);

        // 4. top address 0xFF
        send_frame(10'b00_11111111);
        send_frame(10'b01_01010101);
        send_frame(10'b10_11111111);
        read_frame(rb);
        check("read_addrff", rb, 8'h55);
        check("rd_flag_after_ff", {7'd0, dut.rd_flag}, 8'h00);

        // 5. aborted write-data frame leaves memory untouched
        send_frame(10'b00_00010000);
        send_frame(10'b01_00110011);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 9; i >= 5; i--) tick(1'b0, 10'b01_11000011 >> i);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        send_frame(10'b10_00010000);
        read_frame(rb);
        check("abort_keeps_mem", rb, 8'h33);
        send_frame(10'b01_01110111);
        send_frame(10'b10_00010000);
        read_frame(rb);
        check("after_abort_write", rb, 8'h77);
        send_frame(10'b10_00000001);
        read_frame(rb);
        check("addr01_untouched", rb, 8'h8A);

        // 6. asynchronous reset during MISO transmission
        send_frame(10'b10_00000001);
        frame_bits(10'b11_0000_0000);
        for (int k = 1; k <= 3; k++) tick(1'b0, 1'b0);
        check("miso_bit7_live", {7'd0, MISO}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("async_reset_miso", {7'd0, MISO}, 8'h00);
        SS_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 1'b0);
        check("rd_flag_post_reset", {7'd0, dut.rd_flag}, 8'h00);
        send_frame(10'b10_11111111);
        check("rd_flag_set_again", {7'd0, dut.rd_flag}, 8'h01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rd_flag_async_clear", {7'd0, dut.rd_flag}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(10'b10_11111111);
        read_frame(rb);
        check("ram_survives_reset", rb, 8'h55);
        repeat (3) tick(1'b1, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
